// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit:
// FSM states, opcodes, ALUOp, ImmSrc and ALUControl codes.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_e;

    localparam int NUM_STATES = 12;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_e;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Only add/sub, slt, or and and exist in the ALU; other funct3 codes trap.
    function automatic logic alu_funct3_ok(input logic [2:0] funct3);
        return (funct3 == 3'b000) || (funct3 == 3'b010) ||
               (funct3 == 3'b110) || (funct3 == 3'b111);
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU decoder: maps ALUOp plus instruction funct fields
// to the ALUControl code driven into the datapath ALU.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  aluop_e     aluop_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       op5_i,
    output logic [2:0] alu_control_o
);

    always_comb begin
        // NOTE: default first so every path assigns the output and no latch is inferred.
        alu_control_o = ALU_ADD;
        unique case (aluop_i)
            ALUOP_SUB: alu_control_o = ALU_SUB;
            ALUOP_FUNCT: begin
                unique case (funct3_i)
                    // Only R-type (op[5]=1) can subtract; addi ignores Instr[30].
                    3'b000:  alu_control_o = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control_o = ALU_SLT;
                    3'b110:  alu_control_o = ALU_OR;
                    3'b111:  alu_control_o = ALU_AND;
                    default: alu_control_o = ALU_ADD;
                endcase
            end
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main FSM of the multicycle RV32I core: sequences each instruction and
// decodes datapath enables and mux selects from the current state.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter bit RESET_STATE_ONEHOT = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       RegWrite,
    output logic       trap
);

    state_e state_cur;
    state_e state_d;
    aluop_e alu_op;
    logic   pc_write_raw, mem_write_raw, ir_write_raw, reg_write_raw;

    generate
        if (RESET_STATE_ONEHOT) begin : g_onehot
            logic [NUM_STATES-1:0] onehot_q;
            always_ff @(posedge clk) begin
                // NOTE: non-blocking for all registered state so every flop samples pre-edge values.
                onehot_q <= rst ? (NUM_STATES'(1) << S_FETCH) : (NUM_STATES'(1) << state_d);
            end
            always_comb begin
                state_cur = S_FETCH;
                for (int i = 0; i < NUM_STATES; i++) begin
                    if (onehot_q[i]) state_cur = state_e'(i[3:0]);
                end
            end
        end else begin : g_binary
            state_e state_q;
            always_ff @(posedge clk) begin
                state_q <= rst ? S_FETCH : state_d;
            end
            assign state_cur = state_q;
        end
    endgenerate

    always_comb begin
        state_d = state_cur;
        unique case (state_cur)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                state_d = S_TRAP;
                unique case (op)
                    OP_LW, OP_SW: if (funct3 == 3'b010)   state_d = S_MEMADR;
                    OP_R:         if (alu_funct3_ok(funct3)) state_d = S_EXECUTER;
                    OP_I:         if (alu_funct3_ok(funct3)) state_d = S_EXECUTEI;
                    OP_BEQ:       if (funct3 == 3'b000)   state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_EXECUTER, S_EXECUTEI, S_JAL: state_d = S_ALUWB;
            S_MEMWB, S_ALUWB, S_BEQ:       state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pc_write_raw  = 1'b0;
        AdrSrc        = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        alu_op        = ALUOP_ADD;
        reg_write_raw = 1'b0;
        trap          = 1'b0;
        unique case (state_cur)
            S_FETCH: begin
                ALUSrcB      = 2'b10;
                ResultSrc    = 2'b10;
                ir_write_raw = mem_ready;
                pc_write_raw = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc     = 2'b01;
                reg_write_raw = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc        = 1'b1;
                mem_write_raw = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = 2'b10;
                alu_op  = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = ALUOP_FUNCT;
            end
            S_ALUWB: reg_write_raw = 1'b1;
            S_BEQ: begin
                ALUSrcA      = 2'b10;
                alu_op       = ALUOP_SUB;
                pc_write_raw = zero;
            end
            S_JAL: begin
                ALUSrcA      = 2'b01;
                ALUSrcB      = 2'b10;
                pc_write_raw = 1'b1;
            end
            S_TRAP:  trap = 1'b1;
            default: trap = 1'b0;
        endcase
    end

    // Reset must block architectural writes even if the old state wants one.
    assign PCWrite  = pc_write_raw  & ~rst;
    assign MemWrite = mem_write_raw & ~rst;
    assign IRWrite  = ir_write_raw  & ~rst;
    assign RegWrite = reg_write_raw & ~rst;

    always_comb begin
        unique case (op)
            OP_SW:   ImmSrc = IMM_S;
            OP_BEQ:  ImmSrc = IMM_B;
            OP_JAL:  ImmSrc = IMM_J;
            default: ImmSrc = IMM_I;
        endcase
    end

    alu_decoder u_alu_decoder (
        .aluop_i       (alu_op),
        .funct3_i      (funct3),
        .funct7b5_i    (funct7b5),
        .op5_i         (op[5]),
        .alu_control_o (ALUControl)
    );

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Main control unit for the multicycle RV32I core. Sequences fetch, decode, execute, memory and writeback over several cycles, and drives the datapath enables and mux selects, including ImmSrc to the immediate extender. Sits beside the datapath and takes opcode/funct fields from the instruction register. Adds a memory wait handshake and a trap state for unsupported encodings.

Parameters:
RESET_STATE_ONEHOT, 0, 1 = one-hot state register; 0 = binary state register. Behaviour is identical in both cases.

Ports:
clk  in  1  clock; everything is on the rising edge.
rst  in  1  reset: synchronous, active-high.
op  in  7  Instr[6:0].
funct3  in  3  Instr[14:12].
funct7b5  in  1  Instr[30].
zero  in  1  ALU zero flag.
mem_ready  in  1  memory access completes this cycle.
PCWrite  out  1  PC register enable.
AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut/Result.
MemWrite  out  1  data memory write enable.
IRWrite  out  1  instruction register (and OldPC) enable.
ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1.
ALUSrcB  out  2  ALU B select: 00 = rs2, 01 = ImmExt, 10 = constant 4.
ImmSrc  out  2  immediate type: 00 = I, 01 = S, 10 = B, 11 = J (extender J case added alongside this block).
ALUControl  out  3  000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
RegWrite  out  1  register file write enable.
trap  out  1  high while in TRAP.

Behaviour:
- State register updates on posedge clk. rst=1 makes next state FETCH.
- While rst=1, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0. After reset, state = FETCH and trap = 0.
- Outputs are combinational from the registered state, plus mem_ready, zero, funct3, funct7b5 and op[5].
- Unlisted outputs are 0 in each state. ImmSrc is decoded from op in every state. Unknown op gives ImmSrc = 00.
- Supported opcodes:
  - lw 0000011, funct3 must be 010.
  - sw 0100011, funct3 must be 010.
  - R-type 0110011.
  - I-ALU 0010011.
  - beq 1100011, funct3 must be 000.
  - jal 1101111.
  - R-type and I-ALU accept funct3 000, 010, 110, 111.
- State actions:
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=add, ResultSrc=10. IRWrite = PCWrite = mem_ready. If mem_ready=0, stay in FETCH; else go to DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=add (branch target). Next state by op: lw/sw -> MEMADR, R -> EXECUTER, I -> EXECUTEI, beq -> BEQ, jal -> JAL. Any unsupported op/funct3 combination -> TRAP.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, add. lw -> MEMREAD, sw -> MEMWRITE.
  - MEMREAD: ResultSrc=00, AdrSrc=1. Stay until mem_ready, then go to MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1. Then FETCH.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1, held until mem_ready. Then FETCH.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=funct. Then ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=funct. Then ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. Then FETCH.
  - BEQ: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, PCWrite=zero. Then FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1. Then ALUWB.
  - TRAP: trap=1, all enables 0. Stays in TRAP until rst.
- ALU decode (ALUOp=funct):
  - funct3 000: sub if op[5] & funct7b5, else add.
  - funct3 010: slt.
  - funct3 110: or.
  - funct3 111: and.
- Latency with mem_ready held high: lw 5 cycles, sw 4, R/I 4, beq 3, jal 4. Each mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Reset mid-instruction: no write enable is asserted in the reset cycle, and FETCH is the state on the next cycle.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - state enum;
  - opcode constants;
  - ALUOp encoding (add, sub, funct);
  - ImmSrc encodings;
  - ALUControl encodings.
- One sub-module, alu_decoder: purely combinational, ALUOp/funct3/funct7b5/op5 -> ALUControl.
- The FSM and output decode stay in multicycle_controller.

Test Plan:
1. Assert rst for 2 cycles mid-MEMWRITE (sw, mem_ready=1) -> MemWrite=0 during rst; FETCH with ALUSrcB=10 the cycle after release; trap=0.
2. lw (op=0000011, funct3=010), mem_ready low for 2 cycles in MEMREAD -> 7 cycles total; RegWrite=1 with ResultSrc=01 only in the last cycle; ImmSrc=00.
3. R-type sub (op=0110011, funct3=000, funct7b5=1) -> ALUControl=001 in EXECUTER; RegWrite=1 in cycle 4; 4 cycles total.
4. beq with zero=1, then with zero=0 -> PCWrite=1 in cycle 3 only in the first case; ALUControl=001; ImmSrc=10; 3 cycles each.
5. sw (op=0100011) -> ImmSrc=01; MemWrite=1 and AdrSrc=1 in cycle 4; RegWrite never asserted.
6. op=1111111 -> TRAP after DECODE; trap=1 and all enables 0 for 10 cycles; rst returns the FSM to FETCH.
